uart_rx: RTL and testbench

UART receiver, 8N1, LSB first: the stage directly downstream of the UART transmitter. It deserializes the RxD line, sampling at 16x baud using the same accumulator-style baud generator as the transmitter. Each received byte is presented with a one-cycle valid strobe. Stop-bit violations are flagged with a framing-error strobe. Typical use: loopback of the transmitter's TxD (115200 baud, 50 MHz) into LED/HEX display logic.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver. 16x oversampling and a 3-sample majority vote.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int AccWidth     = 17,
  // Rounded Baud*16*2^AccWidth/ClkFrequency, arranged to stay inside 32-bit math
  parameter int Inc          = ((Baud << (AccWidth - 4)) + (ClkFrequency >> 9))
                               / (ClkFrequency >> 8)
) (
  input  logic       CLK_50,
  input  logic       RESET,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy,
  output logic       Tick16
);

  localparam logic [AccWidth:0] c_inc = (AccWidth + 1)'(Inc);

  typedef enum logic [2:0] {
    S_WAITHI = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [AccWidth:0] acc_q;
  logic [1:0]        sync_q;
  logic [3:0]        scnt_q, scnt_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [1:0]        smp_q, smp_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  logic              w_tick;
  logic              w_rxs;
  logic [3:0]        w_scnt_nxt;
  logic              w_vote;
  logic              w_decide;

  assign w_tick     = acc_q[AccWidth];
  assign w_rxs      = sync_q[1];
  assign w_scnt_nxt = scnt_q + 4'd1;
  // The third vote sample is the live synchronized line at the decision tick.
  assign w_vote     = (smp_q[1] & smp_q[0]) | (smp_q[1] & w_rxs) | (smp_q[0] & w_rxs);
  assign w_decide   = w_tick && (w_scnt_nxt == 4'd9);

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      acc_q    <= '0;
      sync_q   <= 2'b11;
      state_q  <= S_WAITHI;
      scnt_q   <= 4'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      smp_q    <= 2'b00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      acc_q    <= {1'b0, acc_q[AccWidth-1:0]} + c_inc;
      sync_q   <= {sync_q[0], RxD};
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      smp_q    <= smp_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    smp_d    = smp_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    if (w_tick) begin
      scnt_d = w_scnt_nxt;
      if (w_scnt_nxt == 4'd7) smp_d[1] = w_rxs;
      if (w_scnt_nxt == 4'd8) smp_d[0] = w_rxs;
    end

    unique case (state_q)
      S_WAITHI: begin
        if (w_tick && w_rxs) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (w_tick && !w_rxs) begin
          scnt_d  = 4'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_decide) begin
          if (!w_vote) begin
            bitcnt_d = 3'd0;
            state_d  = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_decide) begin
          shreg_d  = {w_vote, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_decide) begin
          if (w_vote) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAITHI;
          end
        end
      end
      default: state_d = S_WAITHI;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign Tick16       = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx at 115200 baud / 50 MHz.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int BitCyc = 434;

  logic       CLK_50 = 1'b0;
  logic       RESET  = 1'b1;
  logic       RxD    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  logic       Tick16;

  uart_rx dut (
    .CLK_50       (CLK_50),
    .RESET        (RESET),
    .RxD          (RxD),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .Tick16       (Tick16)
  );

  always #10 CLK_50 = ~CLK_50;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  rx_q[$];
  int          n_ferr   = 0;
  int          n_bad    = 0;
  logic        prev_v   = 1'b0;
  logic        prev_f   = 1'b0;
  int unsigned cyc      = 0;
  int unsigned t_start  = 0;
  int unsigned t_valid  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK_50) cyc <= cyc + 1;

  // Strobe monitor: collects bytes and counts overlapping or stretched strobes.
  always @(negedge CLK_50) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      t_valid = cyc;
    end
    if (rx_frame_err) n_ferr++;
    if ((rx_valid && rx_frame_err) || (rx_valid && prev_v) || (rx_frame_err && prev_f))
      n_bad++;
    prev_v = rx_valid;
    prev_f = rx_frame_err;
  end

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge CLK_50);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bl);
    RxD     = 1'b0;
    t_start = cyc;
    repeat (bl) @(negedge CLK_50);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (bl) @(negedge CLK_50);
    end
    RxD = stop_bit;
    repeat (bl) @(negedge CLK_50);
  endtask

  task automatic clear_log();
    rx_q.delete();
    n_ferr = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ticks;
    int c;
    int lat;
    logic [7:0] stream [4];
    stream = '{8'h75, 8'h4C, 8'h61, 8'h62};

    // Reset hold
    @(negedge CLK_50);
    repeat (5) @(negedge CLK_50);
    check_eq("rst_data",  rx_data,      8'h00);
    check_eq("rst_valid", rx_valid,     1'b0);
    check_eq("rst_ferr",  rx_frame_err, 1'b0);
    check_eq("rst_busy",  rx_busy,      1'b0);
    check_eq("rst_tick",  Tick16,       1'b0);
    RESET = 1'b0;

    // Tick16 rate: 1000 ticks should take ~27126 cycles
    c = 0;
    while (!Tick16 && c < 100) begin
      @(negedge CLK_50);
      c++;
    end
    check_eq("first_tick", Tick16, 1'b1);
    ticks = 0;
    c     = 0;
    while (ticks < 1000 && c < 30000) begin
      @(negedge CLK_50);
      c++;
      if (Tick16) ticks++;
    end
    check_eq("tick_count",  ticks, 1000);
    check_eq("tick_period", (c >= 27100 && c <= 27150), 1'b1);
    idle(BitCyc);

    // Single byte and latency
    clear_log();
    send_frame(8'h75, 1'b1, BitCyc);
    idle(BitCyc);
    check_eq("single_cnt",  rx_q.size(), 1);
    check_eq("single_data", rx_q[0], 8'h75);
    check_eq("single_ferr", n_ferr, 0);
    lat = int'(t_valid - t_start);
    check_eq("single_latency", (lat >= 4120 && lat <= 4200), 1'b1);

    // Back-to-back stream
    clear_log();
    for (int k = 0; k < 4; k++) send_frame(stream[k], 1'b1, BitCyc);
    idle(BitCyc);
    check_eq("stream_cnt", rx_q.size(), 4);
    for (int k = 0; k < 4; k++) check_eq($sformatf("stream_data%0d", k), rx_q[k], stream[k]);
    check_eq("stream_ferr", n_ferr, 0);

    // Glitch reject
    clear_log();
    RxD = 1'b0;
    repeat (80) @(negedge CLK_50);
    idle(2 * BitCyc);
    check_eq("glitch_cnt",  rx_q.size(), 0);
    check_eq("glitch_ferr", n_ferr, 0);
    check_eq("glitch_busy", rx_busy, 1'b0);
    send_frame(8'h35, 1'b1, BitCyc);
    idle(BitCyc);
    check_eq("post_glitch_cnt",  rx_q.size(), 1);
    check_eq("post_glitch_data", rx_q[0], 8'h35);

    // Framing error, then line held low
    clear_log();
    send_frame(8'hA5, 1'b0, BitCyc);
    repeat (2 * BitCyc) @(negedge CLK_50);
    check_eq("ferr_cnt",   n_ferr, 1);
    check_eq("ferr_valid", rx_q.size(), 0);
    check_eq("ferr_hold",  rx_data, 8'h35);
    check_eq("ferr_busy",  rx_busy, 1'b0);
    idle(BitCyc);
    send_frame(8'h3C, 1'b1, BitCyc);
    idle(BitCyc);
    check_eq("post_ferr_cnt",  rx_q.size(), 1);
    check_eq("post_ferr_data", rx_q[0], 8'h3C);
    check_eq("post_ferr_errs", n_ferr, 1);

    // Reset during bit 4 of 0xFF; line continues the frame afterwards
    clear_log();
    RxD = 1'b0;
    repeat (BitCyc) @(negedge CLK_50);
    RxD = 1'b1;
    repeat (4 * BitCyc + 200) @(negedge CLK_50);
    RESET = 1'b1;
    repeat (5) @(negedge CLK_50);
    RESET = 1'b0;
    repeat (4 * BitCyc - 205 + BitCyc) @(negedge CLK_50);
    idle(BitCyc);
    check_eq("rstmid_cnt",  rx_q.size(), 0);
    check_eq("rstmid_ferr", n_ferr, 0);
    check_eq("rstmid_data", rx_data, 8'h00);
    send_frame(8'h12, 1'b1, BitCyc);
    idle(BitCyc);
    send_frame(8'h12, 1'b1, 447);
    idle(BitCyc);
    send_frame(8'h12, 1'b1, 421);
    idle(BitCyc);
    check_eq("baud_cnt", rx_q.size(), 3);
    check_eq("baud_nom", rx_q[0], 8'h12);
    check_eq("baud_slow", rx_q[1], 8'h12);
    check_eq("baud_fast", rx_q[2], 8'h12);
    check_eq("baud_ferr", n_ferr, 0);

    check_eq("strobe_shape", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
